// File: rtl/min_reduce_pkg.sv
// rtl/min_reduce_pkg.sv - shared state encoding and default widths for min_reduce_uint16
package min_reduce_pkg;

  localparam int DEF_WIDTH     = 16;
  localparam int DEF_CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    S_FIRST = 2'd0,
    S_ACC   = 2'd1,
    S_OUT   = 2'd2
  } state_t;

endpackage

// File: rtl/gt_uint_nbit.sv
// rtl/gt_uint_nbit.sv - unsigned greater-than comparator, N bits wide
module gt_uint_nbit #(
  parameter int N = 16
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic         gt_o
);

  assign gt_o = (a_i > b_i);

endmodule

// File: rtl/min_uint16.sv
// rtl/min_uint16.sv - unsigned minimum of two words; ties resolve to operand A
module min_uint16 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] min_o,
  output logic             b_lt_a_o
);

  logic a_gt_b;

  gt_uint_nbit #(.N(WIDTH)) u_gt (
    .a_i  (a_i),
    .b_i  (b_i),
    .gt_o (a_gt_b)
  );

  assign min_o    = a_gt_b ? b_i : a_i;
  assign b_lt_a_o = a_gt_b;

endmodule

// File: rtl/min_reduce_uint16.sv
// rtl/min_reduce_uint16.sv - frame min-reduction: min value, first index and saturating beat count
module min_reduce_uint16
  import min_reduce_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_min,
  output logic [CNT_WIDTH-1:0] out_index,
  output logic [CNT_WIDTH-1:0] out_count,
  output logic                 out_overflow
);

  state_t               state_q;
  logic [WIDTH-1:0]     acc_q;
  logic [CNT_WIDTH-1:0] idx_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 ovf_q;

  logic [WIDTH-1:0]     min_val;
  logic                 new_min;
  logic                 beat;
  logic                 cnt_sat;

  assign in_ready  = (state_q != S_OUT);
  assign out_valid = (state_q == S_OUT);
  assign beat      = in_valid && in_ready;
  assign cnt_sat   = &cnt_q;

  min_uint16 #(.WIDTH(WIDTH)) u_min (
    .a_i      (acc_q),
    .b_i      (in_data),
    .min_o    (min_val),
    .b_lt_a_o (new_min)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FIRST;
      acc_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        S_FIRST: begin
          if (beat) begin
            acc_q   <= in_data;
            idx_q   <= '0;
            cnt_q   <= CNT_WIDTH'(1);
            ovf_q   <= 1'b0;
            state_q <= in_last ? S_OUT : S_ACC;
          end
        end
        S_ACC: begin
          if (beat) begin
            // Strict less-than keeps the earliest index on ties.
            if (new_min) begin
              acc_q <= min_val;
              idx_q <= cnt_q;
            end
            if (cnt_sat) begin
              ovf_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
            if (in_last) begin
              state_q <= S_OUT;
            end
          end
        end
        S_OUT: begin
          if (out_ready) begin
            state_q <= S_FIRST;
          end
        end
        default: state_q <= S_FIRST;
      endcase
    end
  end

  assign out_min      = acc_q;
  assign out_index    = idx_q;
  assign out_count    = cnt_q;
  assign out_overflow = ovf_q;

endmodule

// File: tb/tb_min_reduce_uint16.sv
// tb/tb_min_reduce_uint16.sv - self-checking bench for min_reduce_uint16 (16-bit and 2-bit counters)
module tb_min_reduce_uint16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready, a_out_overflow;
  logic [15:0] a_in_data, a_out_min, a_out_index, a_out_count;
  logic        b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_overflow;
  logic [15:0] b_in_data, b_out_min;
  logic [1:0]  b_out_index, b_out_count;

  int checks   = 0;
  int failures = 0;
  int frame_q[$];

  min_reduce_uint16 #(.WIDTH(16), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_last(a_in_last),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_min(a_out_min),
    .out_index(a_out_index), .out_count(a_out_count), .out_overflow(a_out_overflow)
  );

  min_reduce_uint16 #(.WIDTH(16), .CNT_WIDTH(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_min(b_out_min),
    .out_index(b_out_index), .out_count(b_out_count), .out_overflow(b_out_overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int d, input logic v, input int data, input logic last);
    if (d == 0) begin
      a_in_valid = v; a_in_data = 16'(data); a_in_last = last;
    end else begin
      b_in_valid = v; b_in_data = 16'(data); b_in_last = last;
    end
  endtask

  task automatic set_ordy(input int d, input logic r);
    if (d == 0) a_out_ready = r;
    else        b_out_ready = r;
  endtask

  function automatic logic rdy(input int d);
    return (d == 0) ? a_in_ready : b_in_ready;
  endfunction

  function automatic logic vld(input int d);
    return (d == 0) ? a_out_valid : b_out_valid;
  endfunction

  task automatic check_outs(input int d, input string tag, input int emin, input int eidx,
                            input int ecnt, input logic eovf);
    if (d == 0) begin
      check({tag, "_min"}, 32'(a_out_min), 32'(emin));
      check({tag, "_index"}, 32'(a_out_index), 32'(eidx));
      check({tag, "_count"}, 32'(a_out_count), 32'(ecnt));
      check({tag, "_ovf"}, 32'(a_out_overflow), 32'(eovf));
    end else begin
      check({tag, "_min"}, 32'(b_out_min), 32'(emin));
      check({tag, "_index"}, 32'(b_out_index), 32'(eidx));
      check({tag, "_count"}, 32'(b_out_count), 32'(ecnt));
      check({tag, "_ovf"}, 32'(b_out_overflow), 32'(eovf));
    end
  endtask

  // Called at a negedge; returns at the negedge after the beat is taken.
  task automatic send_beat(input int d, input int data, input logic last, output int waits);
    set_in(d, 1'b1, data, last);
    waits = 0;
    while (!rdy(d) && waits < 50) begin
      @(posedge clk); @(negedge clk);
      waits++;
    end
    if (waits >= 50) check("accept_timeout", 32'(rdy(d)), 32'd1);
    else begin
      @(posedge clk); @(negedge clk);
    end
    set_in(d, 1'b0, int'($urandom), 1'($urandom));
  endtask

  // Reference: minimum, first index (clamped to the saturated count), saturating count.
  task automatic model(input int cw, output int emin, output int eidx, output int ecnt,
                       output logic eovf);
    int maxc = (1 << cw) - 1;
    int n    = frame_q.size();
    emin = frame_q[0];
    eidx = 0;
    for (int i = 1; i < n; i++) begin
      if (frame_q[i] < emin) begin
        emin = frame_q[i];
        eidx = (i > maxc) ? maxc : i;
      end
    end
    ecnt = (n > maxc) ? maxc : n;
    eovf = (n > maxc);
  endtask

  task automatic get_result(input int d, input string tag, input int hold);
    int emin, eidx, ecnt;
    logic eovf;
    model((d == 0) ? 16 : 2, emin, eidx, ecnt, eovf);
    check({tag, "_latency_valid"}, 32'(vld(d)), 32'd1);
    for (int h = 0; h < hold; h++) begin
      check({tag, "_hold_valid"}, 32'(vld(d)), 32'd1);
      check({tag, "_hold_in_ready"}, 32'(rdy(d)), 32'd0);
      check_outs(d, {tag, "_hold"}, emin, eidx, ecnt, eovf);
      @(posedge clk); @(negedge clk);
    end
    check_outs(d, tag, emin, eidx, ecnt, eovf);
    set_ordy(d, 1'b1);
    @(posedge clk); @(negedge clk);
    set_ordy(d, 1'b0);
    check({tag, "_consumed_valid"}, 32'(vld(d)), 32'd0);
    check({tag, "_consumed_in_ready"}, 32'(rdy(d)), 32'd1);
  endtask

  task automatic run_frame(input int d, input string tag, input int hold, input int gap);
    int w;
    for (int i = 0; i < frame_q.size(); i++) begin
      send_beat(d, frame_q[i], (i == frame_q.size() - 1), w);
      if (i != frame_q.size() - 1) begin
        repeat (gap) begin
          set_in(d, 1'b0, int'($urandom), 1'($urandom));
          @(posedge clk); @(negedge clk);
        end
      end
    end
    get_result(d, tag, hold);
  endtask

  initial begin
    int w;
    rst_n = 1'b0;
    set_in(0, 1'b0, 0, 1'b0); set_in(1, 1'b0, 0, 1'b0);
    a_out_ready = 1'b0; b_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_valid_a", 32'(a_out_valid), 32'd0);
    check_outs(0, "reset_a", 0, 0, 0, 1'b0);
    check_outs(1, "reset_b", 0, 0, 0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready_a", 32'(a_in_ready), 32'd1);
    check("reset_in_ready_b", 32'(b_in_ready), 32'd1);

    // {40,7,99,7} with out_ready held high: result one cycle, lasts one cycle.
    a_out_ready = 1'b1;
    send_beat(0, 40, 1'b0, w);
    send_beat(0, 7, 1'b0, w);
    send_beat(0, 99, 1'b0, w);
    send_beat(0, 7, 1'b1, w);
    check("t1_valid", 32'(a_out_valid), 32'd1);
    check_outs(0, "t1", 7, 1, 4, 1'b0);
    @(posedge clk); @(negedge clk);
    check("t1_valid_one_cycle", 32'(a_out_valid), 32'd0);
    a_out_ready = 1'b0;

    frame_q = '{65535};
    run_frame(0, "single_ffff", 0, 0);

    frame_q = '{5, 3};
    run_frame(0, "backpressure", 4, 0);
    send_beat(0, 9, 1'b1, w);
    check("bp_next_accept_waits", 32'(w), 32'd0);
    frame_q = '{9};
    get_result(0, "bp_next", 0);

    frame_q = '{300, 0, 12};
    run_frame(0, "gapped", 0, 2);

    send_beat(0, 2, 1'b0, w);
    send_beat(0, 1, 1'b0, w);
    rst_n = 1'b0;
    #1;
    check("midreset_valid", 32'(a_out_valid), 32'd0);
    check_outs(0, "midreset", 0, 0, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    frame_q = '{8};
    run_frame(0, "after_reset", 0, 0);

    frame_q = '{9, 9, 9, 9, 1};
    run_frame(1, "sat_cw2", 0, 0);

    for (int f = 0; f < 12; f++) begin
      int len = $urandom_range(1, 8);
      frame_q.delete();
      for (int i = 0; i < len; i++)
        frame_q.push_back(($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7))
                                                      : int'($urandom_range(0, 65535)));
      run_frame(0, "rand_a", $urandom_range(0, 2), $urandom_range(0, 1));
    end

    for (int f = 0; f < 12; f++) begin
      int len = $urandom_range(1, 7);
      frame_q.delete();
      for (int i = 0; i < len; i++) frame_q.push_back(int'($urandom_range(0, 5)));
      run_frame(1, "rand_b", $urandom_range(0, 2), $urandom_range(0, 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
